// File: rtl/daq_sample_framer.sv
// Buffers 16-bit DAQ samples in a FIFO and streams them as framed bytes:
// SYNC, SEQ, N big-endian samples, then an XOR checksum over SEQ and sample bytes.
module daq_sample_framer #(
  parameter int unsigned SAMPLES_PER_FRAME = 8,
  parameter int unsigned FIFO_DEPTH        = 16,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic        overflow_o,
  input  logic        clr_overflow_i,
  output logic [15:0] frame_count_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned IW = $clog2(SAMPLES_PER_FRAME + 1);
  localparam logic [CW-1:0] FRAME_SAMPLES = CW'(SAMPLES_PER_FRAME);
  localparam logic [CW-1:0] FULL_COUNT    = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX      = IW'(SAMPLES_PER_FRAME - 1);

  typedef enum logic [2:0] {IDLE, HDR, SEQ, MSB, LSB, CSUM} state_e;

  logic [15:0]   fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q, rdPtrNext;
  logic [CW-1:0] count_q, count_d;
  logic          full, push, pop, xfer, frameReady;
  logic [15:0]   headSample, nextSample;

  state_e        state_q;
  logic [7:0]    byte_q, seq_q, csum_q;
  logic          byteValid_q, overflow_q;
  logic [IW-1:0] sampleIdx_q;
  logic [15:0]   frameCount_q;

  // Fullness is the registered count, so a push on a full FIFO drops even if a pop happens too.
  assign full       = (count_q == FULL_COUNT);
  assign push       = sample_valid_i && !full;
  assign xfer       = byteValid_q && byte_ready_i;
  assign pop        = xfer && (state_q == LSB);
  assign rdPtrNext  = rdPtr_q + PW'(1);
  assign count_d    = count_q + CW'(push) - CW'(pop);
  assign frameReady = (count_q >= FRAME_SAMPLES);
  assign headSample = fifoMem_q[rdPtr_q];
  assign nextSample = fifoMem_q[rdPtrNext];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= sample_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtrNext;
      end
      count_q <= count_d;
      if (sample_valid_i && full) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Each state names the byte currently presented; the next byte is loaded on its transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      byte_q       <= 8'h00;
      byteValid_q  <= 1'b0;
      seq_q        <= 8'h00;
      csum_q       <= 8'h00;
      sampleIdx_q  <= '0;
      frameCount_q <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (frameReady) begin
            state_q     <= HDR;
            byte_q      <= SYNC_BYTE;
            byteValid_q <= 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            state_q <= SEQ;
            byte_q  <= seq_q;
          end
        end
        SEQ: begin
          if (xfer) begin
            state_q     <= MSB;
            byte_q      <= headSample[15:8];
            csum_q      <= byte_q;
            sampleIdx_q <= '0;
          end
        end
        MSB: begin
          if (xfer) begin
            state_q <= LSB;
            byte_q  <= headSample[7:0];
            csum_q  <= csum_q ^ byte_q;
          end
        end
        LSB: begin
          if (xfer) begin
            csum_q <= csum_q ^ byte_q;
            if (sampleIdx_q == LAST_IDX) begin
              state_q <= CSUM;
              byte_q  <= csum_q ^ byte_q;
            end else begin
              // The head is popped on this edge, so the following sample is one slot ahead.
              state_q     <= MSB;
              byte_q      <= nextSample[15:8];
              sampleIdx_q <= sampleIdx_q + IW'(1);
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            seq_q        <= seq_q + 8'd1;
            frameCount_q <= frameCount_q + 16'd1;
            if (frameReady) begin
              state_q <= HDR;
              byte_q  <= SYNC_BYTE;
            end else begin
              state_q     <= IDLE;
              byteValid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          byteValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_o        = byte_q;
  assign byte_valid_o  = byteValid_q;
  assign overflow_o    = overflow_q;
  assign frame_count_o = frameCount_q;

endmodule

// File: tb/tb_daq_sample_framer.sv
// Randomized scoreboard bench for daq_sample_framer: a queue-based frame model predicts
// every byte, and a negedge monitor pops and compares each transferred byte.
module tb_daq_sample_framer;

  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int L     = 3 + 2 * N;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] sample_i = 16'h0000;
  logic        sample_valid_i = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic        byte_ready_i = 1'b0;
  logic        overflow_o;
  logic        clr_overflow_i = 1'b0;
  logic [15:0] frame_count_o;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0]  expQ[$];
  logic [15:0] pendingQ[$];
  int          acceptedCount = 0;
  int          popCount = 0;
  int          posIdx = 0;
  logic [15:0] expFrames = 16'h0000;
  logic [7:0]  modelSeq = 8'h00;
  logic        expOverflow = 1'b0;
  logic        stallPending = 1'b0;
  logic [7:0]  heldByte = 8'h00;

  daq_sample_framer #(
    .SAMPLES_PER_FRAME(N),
    .FIFO_DEPTH(DEPTH),
    .SYNC_BYTE(SYNC)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .sample_i(sample_i),
    .sample_valid_i(sample_valid_i),
    .byte_o(byte_o),
    .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i),
    .overflow_o(overflow_o),
    .clr_overflow_i(clr_overflow_i),
    .frame_count_o(frame_count_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Accepted samples are grouped N at a time into fully formed expected frames.
  function automatic void modelPush(input logic [15:0] s);
    logic [7:0] cs;
    if (acceptedCount - popCount >= DEPTH) begin
      expOverflow = 1'b1;
      return;
    end
    acceptedCount++;
    pendingQ.push_back(s);
    if (pendingQ.size() == N) begin
      expQ.push_back(SYNC);
      expQ.push_back(modelSeq);
      cs = modelSeq;
      for (int i = 0; i < N; i++) begin
        expQ.push_back(pendingQ[i][15:8]);
        expQ.push_back(pendingQ[i][7:0]);
        cs = cs ^ pendingQ[i][15:8] ^ pendingQ[i][7:0];
      end
      expQ.push_back(cs);
      modelSeq = modelSeq + 8'd1;
      pendingQ.delete();
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic rdy);
    sample_i       = d;
    sample_valid_i = v;
    byte_ready_i   = rdy;
    if (v) modelPush(d);
    @(posedge clk_i); #2;
    sample_valid_i = 1'b0;
  endtask

  task automatic applyReset();
    rst_i          = 1'b1;
    sample_valid_i = 1'b0;
    clr_overflow_i = 1'b0;
    #1;
    checkOutput("reset_byte", 32'(byte_o), 32'h00);
    checkOutput("reset_valid", 32'(byte_valid_o), 32'd0);
    checkOutput("reset_overflow", 32'(overflow_o), 32'd0);
    checkOutput("reset_frame_count", 32'(frame_count_o), 32'd0);
    expQ.delete();
    pendingQ.delete();
    acceptedCount = 0;
    popCount      = 0;
    posIdx        = 0;
    expFrames     = 16'h0000;
    modelSeq      = 8'h00;
    expOverflow   = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
  endtask

  task automatic drainAll();
    int guard = 0;
    while (pendingQ.size() != 0) applyStimulus(1'b1, 16'($urandom), 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    while (expQ.size() != 0 && guard < 2000) begin
      @(posedge clk_i); #2;
      guard++;
    end
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
    @(posedge clk_i); #2;
    checkOutput("idle_after_drain", 32'(byte_valid_o), 32'd0);
  endtask

  // Monitor: inputs settle at posedge+2, so the negedge sees exactly what the next edge will use.
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      stallPending = 1'b0;
    end else begin
      checkOutput("frame_count", 32'(frame_count_o), 32'(expFrames));
      if (stallPending) begin
        checkOutput("hold_valid", 32'(byte_valid_o), 32'd1);
        checkOutput("hold_byte", 32'(byte_o), 32'(heldByte));
      end
      if (byte_valid_o && byte_ready_i) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL unexpected_byte: actual %02h required no byte", byte_o);
        end else begin
          checkOutput("stream_byte", 32'(byte_o), 32'(expQ.pop_front()));
        end
        if (posIdx >= 3 && posIdx <= 2 * N + 1 && posIdx % 2 == 1) popCount++;
        if (posIdx == L - 1) begin
          posIdx    = 0;
          expFrames = expFrames + 16'd1;
        end else begin
          posIdx++;
        end
      end
      stallPending = byte_valid_o && !byte_ready_i;
      heldByte     = byte_o;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] basicBytes [L];
    logic [15:0] basicSamples [N];
    int guard;
    logic hit;
    basicSamples = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF1};
    basicBytes   = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h01};

    applyReset();

    // Basic frame: 11 back-to-back bytes, then idle with one frame counted.
    for (int i = 0; i < N; i++) applyStimulus(1'b1, basicSamples[i], 1'b1);
    checkOutput("latency_not_early", 32'(byte_valid_o), 32'd0);
    for (int i = 0; i < L; i++) begin
      @(posedge clk_i); #2;
      checkOutput("basic_valid", 32'(byte_valid_o), 32'd1);
      checkOutput("basic_byte", 32'(byte_o), 32'(basicBytes[i]));
    end
    @(posedge clk_i); #2;
    checkOutput("basic_idle", 32'(byte_valid_o), 32'd0);
    checkOutput("basic_frame_count", 32'(frame_count_o), 32'd1);

    // Back-pressure while 0x56 is presented.
    for (int i = 0; i < N; i++) applyStimulus(1'b1, basicSamples[i], 1'b1);
    guard = 0;
    while (!(byte_valid_o && byte_o == 8'h56) && guard < 100) begin
      @(posedge clk_i); #2;
      guard++;
    end
    checkOutput("bp_found_56", 32'(byte_valid_o && byte_o == 8'h56), 32'd1);
    byte_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #2;
      checkOutput("bp_hold_56", 32'(byte_o), 32'h56);
    end
    drainAll();

    // Partial frame never starts; the N-th sample starts it one edge later.
    for (int i = 0; i < N - 1; i++) applyStimulus(1'b1, 16'($urandom), 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #2;
      checkOutput("partial_no_valid", 32'(byte_valid_o), 32'd0);
    end
    applyStimulus(1'b1, 16'($urandom), 1'b1);
    checkOutput("partial_not_early", 32'(byte_valid_o), 32'd0);
    @(posedge clk_i); #2;
    checkOutput("partial_start_valid", 32'(byte_valid_o), 32'd1);
    checkOutput("partial_start_sync", 32'(byte_o), 32'(SYNC));
    drainAll();

    // Overflow: 17 pushes into depth 16 with no drain.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 16'(i), 1'b0);
    checkOutput("overflow_clear_at_full", 32'(overflow_o), 32'(expOverflow));
    applyStimulus(1'b1, 16'h0010, 1'b0);
    checkOutput("overflow_model", 32'(overflow_o), 32'(expOverflow));
    checkOutput("overflow_set", 32'(overflow_o), 32'd1);
    clr_overflow_i = 1'b1;
    applyStimulus(1'b1, 16'h0011, 1'b0);
    clr_overflow_i = 1'b0;
    checkOutput("overflow_set_wins", 32'(overflow_o), 32'd1);
    clr_overflow_i = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    clr_overflow_i = 1'b0;
    expOverflow = 1'b0;
    checkOutput("overflow_cleared", 32'(overflow_o), 32'd0);
    drainAll();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 600; i++)
      applyStimulus($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) != 0);
    drainAll();
    clr_overflow_i = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b1);
    clr_overflow_i = 1'b0;
    expOverflow = 1'b0;
    checkOutput("overflow_cleared_random", 32'(overflow_o), 32'd0);

    // Reset while the first sample MSB of the third frame is presented.
    applyReset();
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      applyStimulus(i % 3 == 0 && i < 48, 16'(16'h4000 + i), 1'b1);
      if (expFrames == 16'd2 && posIdx == 2 && byte_valid_o) hit = 1'b1;
    end
    checkOutput("reset_point_reached", 32'(hit), 32'd1);
    applyReset();
    for (int i = 0; i < 2 * N * 3; i++)
      applyStimulus(i % 3 == 0, 16'(16'hC000 + i), 1'b1);
    drainAll();
    checkOutput("post_reset_frames", 32'(frame_count_o), 32'd2);

    // Sequence wrap: 257 frames from reset.
    applyReset();
    for (int i = 0; i < 257 * N * 3; i++)
      applyStimulus(i % 3 == 0, 16'($urandom), 1'b1);
    drainAll();
    checkOutput("wrap_frame_count", 32'(frame_count_o), 32'd257);
    checkOutput("wrap_model_seq", 32'(modelSeq), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
